// File: rtl/product_writeback.sv
// Product write-back: normalises multiplier products and stores one batch into a
// DEPTH x 64 result bank with a registered read port. Optional XOR checksum: WB_CHECKSUM_EN.
module product_writeback #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [63:0]       in_product,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [63:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              done,
`ifdef WB_CHECKSUM_EN
    output logic [63:0]       checksum,
`endif
    output logic              overflow
);

    // state   | meaning
    // IDLE    | no batch open, products ignored
    // COLLECT | accepting products into bank[count]
    // FULL    | batch stored, further products flag overflow
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic [63:0]       rd_data_q;
    logic              rd_valid_q;
    logic [63:0]       bank_q [DEPTH];
    logic [63:0]       norm_d;
    logic [63:0]       rd_word_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wptr_d;

    always_comb begin
        norm_d = in_product;
        case (in_mode)
            2'd0: norm_d = {48'b0, in_product[15:0]};
            2'd1: norm_d = {{48{in_product[15]}}, in_product[15:0]};
            2'd2: norm_d = {{32{in_product[31]}}, in_product[31:0]};
            2'd3: norm_d = in_product;
        endcase
    end

    // A start in the same cycle as a handshake discards the handshake.
    assign wr_en_d = (state_q == COLLECT) && in_valid && !start;
    assign wptr_d  = count_q[ADDR_W-1:0];

`ifdef WB_CHECKSUM_EN
    logic [63:0] checksum_q;
    assign checksum = checksum_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef WB_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= COLLECT;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
`ifdef WB_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (start) begin
                        count_q    <= '0;
                        overflow_q <= 1'b0;
`ifdef WB_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                    end else if (in_valid) begin
                        count_q <= count_q + (ADDR_W+1)'(1);
`ifdef WB_CHECKSUM_EN
                        checksum_q <= checksum_q ^ norm_d;
`endif
                        if (count_q == LAST_CNT) begin
                            state_q <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (start) begin
                        state_q    <= COLLECT;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
`ifdef WB_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                    end else if (in_valid) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bank is deliberately left out of reset so a reset batch stays readable.
    always_ff @(posedge clock) begin
        if (!reset && wr_en_d) begin
            bank_q[wptr_d] <= norm_d;
        end
    end

    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_map
            assign rd_word_d = bank_q[rd_addr];
        end else begin : g_part_map
            assign rd_word_d = (rd_addr < ADDR_W'(DEPTH)) ? bank_q[rd_addr] : 64'b0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_word_d;
            end
        end
    end

    assign in_ready = (state_q == COLLECT);
    assign done     = (state_q == FULL);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_product_writeback.sv
// Directed bench for product_writeback: scoreboard queue of expected bank words,
// immediate-assertion checks. Checksum checks compile in with WB_CHECKSUM_EN.
module tb_product_writeback;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              reset, start, in_valid, in_ready;
    logic [1:0]        in_mode;
    logic [63:0]       in_product;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [63:0]       rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              done, overflow;
`ifdef WB_CHECKSUM_EN
    logic [63:0]       checksum;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [63:0] mb [DEPTH];
    logic [63:0] exp_q [$];
    int          wcnt;

    always #5 clock = ~clock;

    product_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_product (in_product),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .done       (done),
`ifdef WB_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .overflow   (overflow)
    );

    function automatic logic [63:0] norm(input logic [1:0] m, input logic [63:0] p);
        logic [63:0] r;
        case (m)
            2'd0:    r = {48'h0, p[15:0]};
            2'd1:    r = p[15] ? {48'hFFFF_FFFF_FFFF, p[15:0]} : {48'h0, p[15:0]};
            2'd2:    r = p[31] ? {32'hFFFF_FFFF, p[31:0]} : {32'h0, p[31:0]};
            default: r = p;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        wcnt  = 0;
        exp_q.delete();
    endtask

    task automatic hs(input logic [1:0] m, input logic [63:0] p);
        in_valid   = 1'b1;
        in_mode    = m;
        in_product = p;
        tick();
        in_valid   = 1'b0;
        mb[wcnt]   = norm(m, p);
        exp_q.push_back(norm(m, p));
        wcnt++;
    endtask

    task automatic rd(input int a, output logic [63:0] d);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(a);
        tick();
        rd_en   = 1'b0;
        chk("rd_valid", {63'b0, rd_valid}, 64'd1);
        d = rd_data;
    endtask

    task automatic readback(input int n, input string tag);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            rd(i, d);
            if (exp_q.size() == 0) begin
                chk({tag, "_queue_empty"}, 64'd0, 64'd1);
            end else begin
                chk(tag, d, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        logic [63:0] d;
        int          rises;
        logic        prev_done;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_mode = 2'd0;
        in_product = '0; rd_en = 1'b0; rd_addr = '0; wcnt = 0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);

        // Batch 1: mode 0, products i*3
        do_start();
        chk("start_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            hs(2'd0, 64'(i * 3));
            if (i == DEPTH - 2) chk("done_before_last", 64'(done), 64'd0);
        end
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_count", 64'(count), 64'd16);
        chk("t1_in_ready", 64'(in_ready), 64'd0);
        rd(5, d);
        chk("t1_addr5", d, 64'h0000_0000_0000_000F);
        tick();
        chk("rd_valid_drop", 64'(rd_valid), 64'd0);
        chk("rd_data_hold", rd_data, 64'h0000_0000_0000_000F);
        readback(DEPTH, "t1_bank");

        // Batch 2: normalisation of each mode, then overflow in FULL
        do_start();
        hs(2'd1, 64'hFFFF_FFFF_FFFF_FF80);
        hs(2'd2, 64'hABCD_0123_7FFF_0000);
        hs(2'd0, 64'hDEAD_0000_0000_8001);
        hs(2'd2, 64'h0000_0000_8000_0001);
        hs(2'd1, 64'hFFFF_FFFF_FFFF_7FFF);
        hs(2'd3, 64'hDEAD_BEEF_CAFE_F00D);
        for (int i = 6; i < DEPTH; i++) begin
            hs(2'($urandom_range(0, 3)), {$urandom, $urandom});
        end
        rd(0, d); chk("m1_neg", d, 64'hFFFF_FFFF_FFFF_FF80);
        rd(1, d); chk("m2_pos", d, 64'h0000_0000_7FFF_0000);
        rd(2, d); chk("m0_zext", d, 64'h0000_0000_0000_8001);
        rd(3, d); chk("m2_neg", d, 64'hFFFF_FFFF_8000_0001);
        rd(4, d); chk("m1_pos", d, 64'h0000_0000_0000_7FFF);
        rd(5, d); chk("m3_raw", d, 64'hDEAD_BEEF_CAFE_F00D);
        in_valid = 1'b1; in_mode = 2'd3; in_product = 64'h1234;
        tick();
        in_valid = 1'b0;
        chk("ovf_set", 64'(overflow), 64'd1);
        tick(); tick();
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd16);
        readback(DEPTH, "ovf_bank");
        do_start();
        chk("restart_ovf", 64'(overflow), 64'd0);
        chk("restart_count", 64'(count), 64'd0);
        chk("restart_in_ready", 64'(in_ready), 64'd1);
        chk("restart_done", 64'(done), 64'd0);

        // Batch 3: stalled stream, done must rise exactly once
        rises = 0;
        prev_done = done;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if ((cyc % 2 == 0) && wcnt < DEPTH) begin
                hs(2'($urandom_range(0, 3)), {$urandom, $urandom});
            end else begin
                tick();
            end
            if (done && !prev_done) rises++;
            prev_done = done;
        end
        chk("stall_done_rises", 64'(rises), 64'd1);
        chk("stall_count", 64'(count), 64'd16);
        readback(DEPTH, "stall_bank");

        // Reset mid-batch at count 7
        do_start();
        for (int i = 0; i < 7; i++) hs(2'd3, 64'hA5A5_0000_0000_0000 | 64'(i));
        chk("pre_rst_count", 64'(count), 64'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        readback(7, "midrst_bank");

        // Products presented in IDLE are ignored
        in_valid = 1'b1; in_mode = 2'd3; in_product = 64'h0BAD_0BAD_0BAD_0BAD;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_ovf", 64'(overflow), 64'd0);
        rd(0, d); chk("idle_addr0", d, mb[0]);
        rd(7, d); chk("idle_addr7", d, mb[7]);

        // Read-before-write and start discarding a concurrent handshake
        do_start();
        rd_en = 1'b1; rd_addr = '0;
        in_valid = 1'b1; in_mode = 2'd3; in_product = 64'h1111_2222_3333_4444;
        tick();
        rd_en = 1'b0; in_valid = 1'b0;
        chk("rbw_old", rd_data, mb[0]);
        mb[0] = 64'h1111_2222_3333_4444;
        rd(0, d); chk("rbw_new", d, mb[0]);
        start = 1'b1; in_valid = 1'b1; in_product = 64'h5555_6666_7777_8888;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("start_hs_count", 64'(count), 64'd0);
        rd(1, d); chk("start_hs_addr1", d, mb[1]);

`ifdef WB_CHECKSUM_EN
        do_start();
        chk("cks_cleared", checksum, 64'd0);
        for (int i = 0; i < DEPTH; i++) hs(2'd3, 64'd1 << i);
        chk("cks_full", checksum, 64'h0000_0000_0000_FFFF);
        do_start();
        chk("cks_restart", checksum, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_writeback.md
Name: product_writeback

Overview:
- Write-side counterpart to the operand-fetch controller: captures the product stream from the multiplier array and writes it into a 16x64 result bank.
- Each product is normalised to 64 bits according to the mode tag that produced it.
- Signals completion once a full batch is stored; the bank is then read back through a registered read port.

Parameters:
DEPTH, 16, number of result entries (one per operand pair of the 32-entry operand bank)
ADDR_W, 4, result address width, must equal clog2(DEPTH)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; clears the write pointer and opens a new batch
in_valid  input  1  product on in_product/in_mode is valid
in_ready  output  1  block can accept a product this cycle
in_mode  input  2  mode tag: 0=u8x8, 1=s8x8, 2=s16x16, 3=s32x32
in_product  input  64  raw product; only the low bits for the mode are meaningful
rd_en  input  1  read strobe
rd_addr  input  ADDR_W  read address
rd_data  output  64  read data, registered
rd_valid  output  1  rd_data is valid
count  output  ADDR_W+1  number of entries written in the current batch
done  output  1  batch complete; high while count==DEPTH
overflow  output  1  sticky; set when in_valid is seen while in FULL

Behaviour:
- Reset (reset=1 at a rising clock edge) forces:
  - state=IDLE, count=0, done=0, overflow=0, in_ready=0, rd_valid=0, rd_data=0.
  - Bank contents are not cleared.
- FSM states: IDLE, COLLECT, FULL.
  - IDLE: in_ready=0. start -> COLLECT; write pointer=0, count=0, overflow=0.
  - COLLECT: in_ready=1. A handshake (in_valid & in_ready) writes the normalised product to bank[wptr], then wptr++ and count++.
  - On the handshake that makes count==DEPTH: -> FULL, done=1 from the next cycle.
  - FULL: in_ready=0, done=1. in_valid=1 sets overflow; the product is dropped and the bank is unchanged. start -> COLLECT (new batch; done drops next cycle).
  - start while in COLLECT restarts the batch: pointer/count cleared, overflow cleared. A handshake in the same cycle as start is discarded.
- Normalisation (combinational, applied before the write):
  - mode 0: {48'b0, in_product[15:0]}
  - mode 1: sign-extend in_product[15:0]
  - mode 2: sign-extend in_product[31:0]
  - mode 3: in_product unchanged
- Write latency: the entry is readable on the cycle after its handshake.
- Read port:
  - rd_en=1 at edge N -> rd_data=bank[rd_addr] and rd_valid=1 after edge N. Otherwise rd_valid=0 and rd_data holds its last value.
  - Reads are legal in every state.
  - A read and a write to the same address in the same cycle return the OLD contents (read-before-write).
  - rd_addr >= DEPTH is not possible when DEPTH=2^ADDR_W; for other DEPTH values, rd_data=0.
- The mode may change on every handshake; each entry uses its own tag.
- A reset asserted mid-batch abandons the batch: count=0, and previously written bank words stay readable.

Optional Feature:
- Macro: WB_CHECKSUM_EN.
- Defined:
  - Adds output checksum[63:0], cleared by reset and by start.
  - On each accepted write, checksum <= checksum ^ normalised_word, updated the cycle after the handshake, alongside count.
  - In FULL, checksum equals the XOR of all DEPTH stored words.
- Not defined: the port is absent and no logic is generated.

Test Plan:
1. Reset, then start, then 16 handshakes, mode 0, in_product=i*3 -> done=1 after the 16th, count=16, in_ready=0; reading addr 5 gives 64'h000000000000000F with rd_valid one cycle after rd_en.
2. Mode 1, in_product=64'hFFFF_FFFF_FFFF_FF80 (low 16 bits 16'hFF80) -> stored 64'hFFFFFFFFFFFFFF80. Mode 2, in_product[31:0]=32'h7FFF0000 -> stored 64'h000000007FFF0000. Mode 0, in_product=64'hDEAD_0000_0000_8001 -> stored 64'h0000000000008001.
3. In FULL, drive in_valid=1 with 64'h1234 -> overflow=1 (sticky), bank unchanged; then start -> overflow=0, count=0, in_ready=1 next cycle.
4. Stall pattern: toggle in_valid every other cycle across 16 products -> all 16 stored in order and done asserts exactly once; with in_valid=1 held in IDLE, nothing is written.
5. In COLLECT with count=7, assert reset -> next cycle state=IDLE, count=0, done=0; addr 0..6 still read back their earlier values.
6. With WB_CHECKSUM_EN, load 1,2,4,...,2^15 in mode 3 -> checksum=64'h000000000000FFFF in FULL; start clears it to 0.
